id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
- Next-generation MIPS decode stage with a registered ID/EX pipeline register.
- Decodes the logic, shift and LUI instruction group.
- Reads the register file combinationally and resolves RAW hazards by forwarding from the EX and MEM stages.
- Detects load-use hazards, requests a stall and inserts a bubble; honours downstream stall and flush.

Parameters:
DATA_W, 32, datapath width; 32 or 64; immediates extended to DATA_W
ADDR_W, 5, register address width
ALUOP_W, 8, aluop code width
ALUSEL_W, 3, alusel code width

Ports:
clk  in  1  clock
rst  in  1  reset
pc_i  in  32  PC of inst_i
inst_i  in  32  instruction from IF/ID
if_valid_i  in  1  inst_i is valid
reg1_data_i  in  DATA_W  regfile port 1 data
reg2_data_i  in  DATA_W  regfile port 2 data
reg1_read_o  out  1  port 1 read enable (comb)
reg2_read_o  out  1  port 2 read enable (comb)
reg1_addr_o  out  ADDR_W  inst_i[25:21] (comb)
reg2_addr_o  out  ADDR_W  inst_i[20:16] (comb)
ex_wreg_i  in  1  EX stage writes a register
ex_wd_i  in  ADDR_W  EX destination
ex_wdata_i  in  DATA_W  EX result
ex_is_load_i  in  1  EX instruction is a load
mem_wreg_i  in  1  MEM stage writes a register
mem_wd_i  in  ADDR_W  MEM destination
mem_wdata_i  in  DATA_W  MEM result
stall_ex_i  in  1  downstream stall; hold ID/EX
flush_i  in  1  squash the instruction in ID
stall_req_o  out  1  ID hazard stall request (comb)
ex_valid_o  out  1  ID/EX holds a real instruction
ex_pc_o  out  32  PC
ex_aluop_o  out  ALUOP_W  ALU operation
ex_alusel_o  out  ALUSEL_W  result select
ex_reg1_o  out  DATA_W  operand 1
ex_reg2_o  out  DATA_W  operand 2
ex_wd_o  out  ADDR_W  destination
ex_wreg_o  out  1  write enable
ex_invalid_o  out  1  reserved instruction

Behaviour:
- Reset: rst is synchronous, active-high. All ex_* outputs clear to 0: aluop NOP=8'h00, alusel NOP=3'b000.
- While rst is high, the combinational read enables and stall_req_o are forced to 0.
- Decode (comb):
  - SPECIAL (op=0), by funct:
    - AND 0x24 / OR 0x25 / XOR 0x26 / NOR 0x27: aluop 8'h24/25/26/27, alusel LOGIC=3'b001, read rs,rt, wd=rd.
    - SLL 0x00 / SRL 0x02 / SRA 0x03: aluop 8'h7C/02/03, alusel SHIFT=3'b010, read rt only, operand1 = sa zero-extended, wd=rd.
    - SLLV 0x04 / SRLV 0x06 / SRAV 0x07: same aluops as the fixed shifts, read rs,rt.
    - SYNC 0x0F: valid NOP, wreg=0.
  - I-type:
    - ANDI 0x0C / ORI 0x0D / XORI 0x0E: read rs, operand2 = imm16 zero-extended, wd=rt.
    - LUI 0x0F: OR with rs, operand2 = {imm16,16'h0} sign-extended to DATA_W.
  - Operand with read disabled takes imm.
  - Anything else: invalid=1, wreg=0, aluop NOP.
- Operand source priority, for a read-enabled operand:
  1. address 0 -> 0.
  2. ex_wreg_i && ex_wd_i==addr -> ex_wdata_i.
  3. mem_wreg_i && mem_wd_i==addr -> mem_wdata_i.
  4. regfile data.
- Load-use: stall_req_o=1 iff if_valid_i && ex_is_load_i && ex_wreg_i && ex_wd_i!=0 && ex_wd_i matches a read-enabled source address. The EX forward is not used in that cycle.
- ID/EX update each clk, in priority order:
  1. rst.
  2. flush_i -> bubble (all ex_* 0).
  3. stall_ex_i -> hold all ex_*.
  4. stall_req_o or !if_valid_i -> bubble.
  5. Else capture the decoded instruction with ex_valid_o=1.
- Timing: latency 1 cycle inst_i -> ex_*. flush_i and stall_ex_i together -> flush wins.
- stall_req_o is independent of stall_ex_i; upstream holds IF/ID while either is high.

Optional Feature:
ID_FWD_EN:
- Defined: forwarding as above.
- Undefined: no forwarding mux; operand = regfile data (0 for address 0). stall_req_o=1 on any match of a read-enabled nonzero source against ex_wd_i (ex_wreg_i) or mem_wd_i (mem_wreg_i). ex_is_load_i is ignored.

Test Plan:
- Reset: rst=1 for 2 clk, then ORI $1,$0,0x1234 -> next clk ex_aluop_o=8'h25, ex_alusel_o=1, ex_reg1_o=0, ex_reg2_o=0x1234, ex_wd_o=1, ex_wreg_o=1, ex_valid_o=1.
- Forward: AND $3,$1,$2 with ex_wd_i=1/ex_wdata_i=0xAA, mem_wd_i=2/mem_wdata_i=0x55, regfile 0 -> ex_reg1_o=0xAA, ex_reg2_o=0x55. With EX and MEM both writing $1 -> EX value wins.
- Load-use: ex_is_load_i=1, ex_wd_i=4, inst OR $5,$4,$6 -> stall_req_o=1, next clk bubble (ex_valid_o=0, ex_wreg_o=0). The load clears, then the instruction issues with the MEM-forwarded value.
- Shifts/LUI: SLL $2,$3,5 -> ex_reg1_o=5, ex_aluop_o=8'h7C, ex_alusel_o=2. LUI $7,0x8001 with DATA_W=64 -> ex_reg2_o=64'hFFFFFFFF80010000.
- Control: stall_ex_i=1 -> ex_* held 3 cycles. flush_i with stall_ex_i -> bubble. Invalid op 0x3F -> ex_invalid_o=1, ex_wreg_o=0. Writes to $0 are never forwarded (operand 0).
- ID_FWD_EN undefined: mem_wd_i=2, OR $1,$2,$0 -> stall_req_o=1 until mem_wreg_i drops.

Source files
------------

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS decode stage for the logic / shift / LUI group with a
// registered ID/EX pipeline register, register-file read, RAW forwarding
// and load-use stall detection.
//
// Build option: define ID_FWD_EN to enable forwarding from the EX and MEM
// stages. Without it, operands come straight from the register file and
// the stage stalls on any pending EX/MEM write to a source register.
module id_stage_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    input  logic                if_valid_i,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [ADDR_W-1:0]   reg1_addr_o,
    output logic [ADDR_W-1:0]   reg2_addr_o,
    input  logic                ex_wreg_i,
    input  logic [ADDR_W-1:0]   ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_wreg_i,
    input  logic [ADDR_W-1:0]   mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                stall_ex_i,
    input  logic                flush_i,
    output logic                stall_req_o,
    output logic                ex_valid_o,
    output logic [31:0]         ex_pc_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic [ALUSEL_W-1:0] ex_alusel_o,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [ADDR_W-1:0]   ex_wd_o,
    output logic                ex_wreg_o,
    output logic                ex_invalid_o
);

    localparam logic [ALUOP_W-1:0]  OP_NOP  = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0]  OP_AND  = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0]  OP_OR   = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0]  OP_XOR  = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0]  OP_NOR  = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0]  OP_SLL  = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0]  OP_SRL  = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0]  OP_SRA  = ALUOP_W'(8'h03);
    localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(3'b000);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);

    logic [5:0]          op_s;
    logic [5:0]          funct_s;
    logic [ADDR_W-1:0]   rs_s;
    logic [ADDR_W-1:0]   rt_s;
    logic [ADDR_W-1:0]   rd_s;
    logic [DATA_W-1:0]   imm_zext_s;
    logic [DATA_W-1:0]   imm_lui_s;
    logic [DATA_W-1:0]   imm_sa_s;

    logic [ALUOP_W-1:0]  aluop_s;
    logic [ALUSEL_W-1:0] alusel_s;
    logic                read1_s;
    logic                read2_s;
    logic [ADDR_W-1:0]   wd_s;
    logic                wreg_s;
    logic                invalid_s;
    logic [DATA_W-1:0]   imm_s;

    logic                ex_hit1_s;
    logic                ex_hit2_s;
    logic                mem_hit1_s;
    logic                mem_hit2_s;
    logic [DATA_W-1:0]   opnd1_s;
    logic [DATA_W-1:0]   opnd2_s;
    logic                stall_s;

    assign op_s       = inst_i[31:26];
    assign funct_s    = inst_i[5:0];
    assign rs_s       = ADDR_W'(inst_i[25:21]);
    assign rt_s       = ADDR_W'(inst_i[20:16]);
    assign rd_s       = ADDR_W'(inst_i[15:11]);
    assign imm_zext_s = DATA_W'(inst_i[15:0]);
    assign imm_lui_s  = DATA_W'($signed({inst_i[15:0], 16'h0000}));
    assign imm_sa_s   = DATA_W'(inst_i[10:6]);

    // Instruction decode: ALU controls, read enables, destination, immediate.
    always_comb begin
        aluop_s   = OP_NOP;
        alusel_s  = SEL_NOP;
        read1_s   = 1'b0;
        read2_s   = 1'b0;
        wd_s      = {ADDR_W{1'b0}};
        wreg_s    = 1'b0;
        invalid_s = 1'b0;
        imm_s     = {DATA_W{1'b0}};
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        aluop_s  = ALUOP_W'(funct_s);
                        alusel_s = SEL_LOGIC;
                        read1_s  = 1'b1;
                        read2_s  = 1'b1;
                        wd_s     = rd_s;
                        wreg_s   = 1'b1;
                    end
                    6'h00, 6'h02, 6'h03: begin
                        aluop_s  = (funct_s == 6'h00) ? OP_SLL :
                                   (funct_s == 6'h02) ? OP_SRL : OP_SRA;
                        alusel_s = SEL_SHIFT;
                        read2_s  = 1'b1;
                        imm_s    = imm_sa_s;
                        wd_s     = rd_s;
                        wreg_s   = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07: begin
                        aluop_s  = (funct_s == 6'h04) ? OP_SLL :
                                   (funct_s == 6'h06) ? OP_SRL : OP_SRA;
                        alusel_s = SEL_SHIFT;
                        read1_s  = 1'b1;
                        read2_s  = 1'b1;
                        wd_s     = rd_s;
                        wreg_s   = 1'b1;
                    end
                    6'h0F: begin
                        // SYNC has no effect in this pipeline: a legal NOP.
                        wreg_s = 1'b0;
                    end
                    default: begin
                        invalid_s = 1'b1;
                    end
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                aluop_s  = (op_s == 6'h0C) ? OP_AND :
                           (op_s == 6'h0D) ? OP_OR : OP_XOR;
                alusel_s = SEL_LOGIC;
                read1_s  = 1'b1;
                imm_s    = imm_zext_s;
                wd_s     = rt_s;
                wreg_s   = 1'b1;
            end
            6'h0F: begin
                // LUI is executed as rs | (imm16 << 16).
                aluop_s  = OP_OR;
                alusel_s = SEL_LOGIC;
                read1_s  = 1'b1;
                imm_s    = imm_lui_s;
                wd_s     = rt_s;
                wreg_s   = 1'b1;
            end
            default: begin
                invalid_s = 1'b1;
            end
        endcase
    end

    // Hits only count for enabled, nonzero sources: $0 is never a hazard.
    assign ex_hit1_s  = read1_s && (rs_s != '0) && ex_wreg_i  && (ex_wd_i  == rs_s);
    assign ex_hit2_s  = read2_s && (rt_s != '0) && ex_wreg_i  && (ex_wd_i  == rt_s);
    assign mem_hit1_s = read1_s && (rs_s != '0) && mem_wreg_i && (mem_wd_i == rs_s);
    assign mem_hit2_s = read2_s && (rt_s != '0) && mem_wreg_i && (mem_wd_i == rt_s);

`ifdef ID_FWD_EN
    // Operand select with forwarding: EX result is newer than MEM result.
    always_comb begin
        opnd1_s = {DATA_W{1'b0}};
        opnd2_s = {DATA_W{1'b0}};
        if (!read1_s)         opnd1_s = imm_s;
        else if (ex_hit1_s)   opnd1_s = ex_wdata_i;
        else if (mem_hit1_s)  opnd1_s = mem_wdata_i;
        else if (rs_s == '0)  opnd1_s = {DATA_W{1'b0}};
        else                  opnd1_s = reg1_data_i;
        if (!read2_s)         opnd2_s = imm_s;
        else if (ex_hit2_s)   opnd2_s = ex_wdata_i;
        else if (mem_hit2_s)  opnd2_s = mem_wdata_i;
        else if (rt_s == '0)  opnd2_s = {DATA_W{1'b0}};
        else                  opnd2_s = reg2_data_i;
    end

    // Only a load in EX cannot be forwarded in time.
    always_comb begin
        stall_s = 1'b0;
        if (!rst && if_valid_i && ex_is_load_i && (ex_hit1_s || ex_hit2_s)) stall_s = 1'b1;
        else stall_s = 1'b0;
    end
`else
    logic unused_s;
    assign unused_s = ^{ex_wdata_i, ex_is_load_i, mem_wdata_i};

    // Operand select without forwarding: register file or immediate.
    always_comb begin
        opnd1_s = {DATA_W{1'b0}};
        opnd2_s = {DATA_W{1'b0}};
        if (!read1_s)         opnd1_s = imm_s;
        else if (rs_s == '0)  opnd1_s = {DATA_W{1'b0}};
        else                  opnd1_s = reg1_data_i;
        if (!read2_s)         opnd2_s = imm_s;
        else if (rt_s == '0)  opnd2_s = {DATA_W{1'b0}};
        else                  opnd2_s = reg2_data_i;
    end

    // Any pending EX/MEM write to a source register must drain first.
    always_comb begin
        stall_s = 1'b0;
        if (!rst && if_valid_i &&
            (ex_hit1_s || ex_hit2_s || mem_hit1_s || mem_hit2_s)) stall_s = 1'b1;
        else stall_s = 1'b0;
    end
`endif

    assign stall_req_o = stall_s;
    assign reg1_read_o = rst ? 1'b0 : read1_s;
    assign reg2_read_o = rst ? 1'b0 : read2_s;
    assign reg1_addr_o = rs_s;
    assign reg2_addr_o = rt_s;

    // ID/EX register: reset, flush, downstream hold, bubble, or capture.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= 32'h0000_0000;
            ex_aluop_o   <= OP_NOP;
            ex_alusel_o  <= SEL_NOP;
            ex_reg1_o    <= {DATA_W{1'b0}};
            ex_reg2_o    <= {DATA_W{1'b0}};
            ex_wd_o      <= {ADDR_W{1'b0}};
            ex_wreg_o    <= 1'b0;
            ex_invalid_o <= 1'b0;
        end else if (stall_ex_i) begin
            ex_valid_o   <= ex_valid_o;
            ex_pc_o      <= ex_pc_o;
            ex_aluop_o   <= ex_aluop_o;
            ex_alusel_o  <= ex_alusel_o;
            ex_reg1_o    <= ex_reg1_o;
            ex_reg2_o    <= ex_reg2_o;
            ex_wd_o      <= ex_wd_o;
            ex_wreg_o    <= ex_wreg_o;
            ex_invalid_o <= ex_invalid_o;
        end else if (stall_s || !if_valid_i) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= 32'h0000_0000;
            ex_aluop_o   <= OP_NOP;
            ex_alusel_o  <= SEL_NOP;
            ex_reg1_o    <= {DATA_W{1'b0}};
            ex_reg2_o    <= {DATA_W{1'b0}};
            ex_wd_o      <= {ADDR_W{1'b0}};
            ex_wreg_o    <= 1'b0;
            ex_invalid_o <= 1'b0;
        end else begin
            ex_valid_o   <= 1'b1;
            ex_pc_o      <= pc_i;
            ex_aluop_o   <= aluop_s;
            ex_alusel_o  <= alusel_s;
            ex_reg1_o    <= opnd1_s;
            ex_reg2_o    <= opnd2_s;
            ex_wd_o      <= wd_s;
            ex_wreg_o    <= wreg_s;
            ex_invalid_o <= invalid_s;
        end
    end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed self-checking bench for id_stage_fwd (DATA_W = 64).
module tb_id_stage_fwd;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_i, inst_i;
    logic          if_valid_i;
    logic [DW-1:0] reg1_data_i, reg2_data_i;
    logic          reg1_read_o, reg2_read_o;
    logic [4:0]    reg1_addr_o, reg2_addr_o;
    logic          ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]    ex_wd_i, mem_wd_i;
    logic [DW-1:0] ex_wdata_i, mem_wdata_i;
    logic          stall_ex_i, flush_i, stall_req_o;
    logic          ex_valid_o, ex_wreg_o, ex_invalid_o;
    logic [31:0]   ex_pc_o;
    logic [7:0]    ex_aluop_o;
    logic [2:0]    ex_alusel_o;
    logic [DW-1:0] ex_reg1_o, ex_reg2_o;
    logic [4:0]    ex_wd_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_fwd #(.DATA_W(DW), .ADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .if_valid_i(if_valid_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
        .mem_wdata_i(mem_wdata_i), .stall_ex_i(stall_ex_i), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o),
        .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_invalid_o(ex_invalid_o)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, sa, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_i = 32'h0000_1000; inst_i = 32'h0000_0000; if_valid_i = 1'b1;
        reg1_data_i = '0; reg2_data_i = '0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = '0;
        stall_ex_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        inst_i = rtype(5'd2, 5'd3, 5'd1, 5'd0, 6'h25);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2;
        #1;
        total++; if (reg1_read_o !== 1'b0) begin bad++; $display("FAIL rst_read1: got %0h want 0", reg1_read_o); end
        total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0h want 0", stall_req_o); end
        step(); step();
        total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", ex_valid_o); end
        total++; if (ex_aluop_o !== 8'h00 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL rst_aluop: got %0h/%0h want 0/0", ex_aluop_o, ex_wreg_o); end
        rst = 1'b0; mem_wreg_i = 1'b0;
        inst_i = itype(6'h0D, 5'd0, 5'd1, 16'h1234);
        reg1_data_i = 64'h9999; pc_i = 32'h0000_2000;
        #1;
        total++; if (reg1_read_o !== 1'b1 || reg2_read_o !== 1'b0) begin bad++; $display("FAIL ori_reads: got %0h%0h want 10", reg1_read_o, reg2_read_o); end
        total++; if (reg2_addr_o !== 5'd1) begin bad++; $display("FAIL ori_addr2: got %0h want 1", reg2_addr_o); end
        step();
        total++; if (ex_aluop_o !== 8'h25 || ex_alusel_o !== 3'd1) begin bad++; $display("FAIL ori_ctl: got %0h/%0h want 25/1", ex_aluop_o, ex_alusel_o); end
        total++; if (ex_reg1_o !== 64'h0 || ex_reg2_o !== 64'h1234) begin bad++; $display("FAIL ori_ops: got %0h/%0h want 0/1234", ex_reg1_o, ex_reg2_o); end
        total++; if (ex_wd_o !== 5'd1 || ex_wreg_o !== 1'b1 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL ori_wd: got %0h/%0h/%0h want 1/1/1", ex_wd_o, ex_wreg_o, ex_valid_o); end
        total++; if (ex_pc_o !== 32'h0000_2000) begin bad++; $display("FAIL ori_pc: got %0h want 2000", ex_pc_o); end
    endtask

    task automatic test_logic();
        idle();
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
        reg1_data_i = 64'h11; reg2_data_i = 64'h22;
        step();
        total++; if (ex_reg1_o !== 64'h11 || ex_reg2_o !== 64'h22) begin bad++; $display("FAIL and_ops: got %0h/%0h want 11/22", ex_reg1_o, ex_reg2_o); end
        total++; if (ex_aluop_o !== 8'h24 || ex_wd_o !== 5'd3) begin bad++; $display("FAIL and_ctl: got %0h/%0h want 24/3", ex_aluop_o, ex_wd_o); end
        inst_i = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h27);
        step();
        total++; if (ex_aluop_o !== 8'h27 || ex_wd_o !== 5'd9) begin bad++; $display("FAIL nor_ctl: got %0h/%0h want 27/9", ex_aluop_o, ex_wd_o); end
        inst_i = itype(6'h0E, 5'd1, 5'd4, 16'h8001);
        step();
        total++; if (ex_reg1_o !== 64'h11 || ex_reg2_o !== 64'h8001) begin bad++; $display("FAIL xori_ops: got %0h/%0h want 11/8001", ex_reg1_o, ex_reg2_o); end
        total++; if (ex_aluop_o !== 8'h26 || ex_wd_o !== 5'd4) begin bad++; $display("FAIL xori_ctl: got %0h/%0h want 26/4", ex_aluop_o, ex_wd_o); end
    endtask

`ifdef ID_FWD_EN
    task automatic test_hazard();
        idle();
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 64'hAA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 64'h55;
        #1;
        total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL fwd_nostall: got %0h want 0", stall_req_o); end
        step();
        total++; if (ex_reg1_o !== 64'hAA || ex_reg2_o !== 64'h55) begin bad++; $display("FAIL fwd_ops: got %0h/%0h want aa/55", ex_reg1_o, ex_reg2_o); end
        mem_wd_i = 5'd1; mem_wdata_i = 64'h77;
        step();
        total++; if (ex_reg1_o !== 64'hAA) begin bad++; $display("FAIL fwd_prio: got %0h want aa", ex_reg1_o); end
        ex_wd_i = 5'd0; mem_wd_i = 5'd2; mem_wdata_i = 64'h55;
        inst_i = rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h24);
        step();
        total++; if (ex_reg1_o !== 64'h0 || ex_reg2_o !== 64'h55) begin bad++; $display("FAIL fwd_zero: got %0h/%0h want 0/55", ex_reg1_o, ex_reg2_o); end
        idle();
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd4;
        inst_i = rtype(5'd4, 5'd6, 5'd5, 5'd0, 6'h25);
        #1;
        total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL lu_stall: got %0h want 1", stall_req_o); end
        step();
        total++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %0h/%0h want 0/0", ex_valid_o, ex_wreg_o); end
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 64'hBEEF;
        #1;
        total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL lu_clear: got %0h want 0", stall_req_o); end
        step();
        total++; if (ex_valid_o !== 1'b1 || ex_reg1_o !== 64'hBEEF) begin bad++; $display("FAIL lu_issue: got %0h/%0h want 1/beef", ex_valid_o, ex_reg1_o); end
    endtask
`else
    task automatic test_hazard();
        idle();
        inst_i = rtype(5'd2, 5'd0, 5'd1, 5'd0, 6'h25);
        reg1_data_i = 64'h33; reg2_data_i = 64'h44;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 64'h55;
        #1;
        total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL mem_stall: got %0h want 1", stall_req_o); end
        step();
        total++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL stall_bubble: got %0h/%0h want 0/0", ex_valid_o, ex_wreg_o); end
        step();
        total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL stall_hold: got %0h want 1", stall_req_o); end
        mem_wreg_i = 1'b0;
        #1;
        total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL stall_drop: got %0h want 0", stall_req_o); end
        step();
        total++; if (ex_valid_o !== 1'b1 || ex_reg1_o !== 64'h33 || ex_reg2_o !== 64'h0) begin bad++; $display("FAIL nofwd_ops: got %0h/%0h/%0h want 1/33/0", ex_valid_o, ex_reg1_o, ex_reg2_o); end
        ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_is_load_i = 1'b0;
        #1;
        total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL ex_stall: got %0h want 1", stall_req_o); end
        ex_wd_i = 5'd0; inst_i = rtype(5'd0, 5'd0, 5'd5, 5'd0, 6'h24);
        #1;
        total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL zero_nostall: got %0h want 0", stall_req_o); end
    endtask
`endif

    task automatic test_shift_lui();
        idle();
        inst_i = rtype(5'd0, 5'd3, 5'd2, 5'd5, 6'h00);
        reg1_data_i = 64'h99; reg2_data_i = 64'h77;
        #1;
        total++; if (reg1_read_o !== 1'b0 || reg2_read_o !== 1'b1) begin bad++; $display("FAIL sll_reads: got %0h%0h want 01", reg1_read_o, reg2_read_o); end
        step();
        total++; if (ex_reg1_o !== 64'h5 || ex_reg2_o !== 64'h77) begin bad++; $display("FAIL sll_ops: got %0h/%0h want 5/77", ex_reg1_o, ex_reg2_o); end
        total++; if (ex_aluop_o !== 8'h7C || ex_alusel_o !== 3'd2 || ex_wd_o !== 5'd2) begin bad++; $display("FAIL sll_ctl: got %0h/%0h/%0h want 7c/2/2", ex_aluop_o, ex_alusel_o, ex_wd_o); end
        inst_i = rtype(5'd6, 5'd5, 5'd4, 5'd0, 6'h07);
        reg1_data_i = 64'h10; reg2_data_i = 64'h20;
        step();
        total++; if (ex_aluop_o !== 8'h03 || ex_reg1_o !== 64'h10 || ex_reg2_o !== 64'h20) begin bad++; $display("FAIL srav: got %0h/%0h/%0h want 3/10/20", ex_aluop_o, ex_reg1_o, ex_reg2_o); end
        inst_i = itype(6'h0F, 5'd0, 5'd7, 16'h8001);
        step();
        total++; if (ex_reg2_o !== 64'hFFFF_FFFF_8001_0000 || ex_reg1_o !== 64'h0) begin bad++; $display("FAIL lui_ops: got %0h/%0h want 0/ffffffff80010000", ex_reg1_o, ex_reg2_o); end
        total++; if (ex_aluop_o !== 8'h25 || ex_wd_o !== 5'd7) begin bad++; $display("FAIL lui_ctl: got %0h/%0h want 25/7", ex_aluop_o, ex_wd_o); end
    endtask

    task automatic test_control();
        idle();
        inst_i = itype(6'h0D, 5'd0, 5'd1, 16'h1234);
        step();
        stall_ex_i = 1'b1;
        inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h26);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ex_reg2_o !== 64'h1234 || ex_aluop_o !== 8'h25 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL hold_%0d: got %0h/%0h/%0h want 1234/25/1", i, ex_reg2_o, ex_aluop_o, ex_valid_o); end
        end
        flush_i = 1'b1;
        step();
        total++; if (ex_valid_o !== 1'b0 || ex_reg2_o !== 64'h0) begin bad++; $display("FAIL flush: got %0h/%0h want 0/0", ex_valid_o, ex_reg2_o); end
        flush_i = 1'b0; stall_ex_i = 1'b0;
        inst_i = {6'h3F, 26'h0};
        step();
        total++; if (ex_invalid_o !== 1'b1 || ex_wreg_o !== 1'b0 || ex_aluop_o !== 8'h00) begin bad++; $display("FAIL invalid: got %0h/%0h/%0h want 1/0/0", ex_invalid_o, ex_wreg_o, ex_aluop_o); end
        inst_i = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h0F);
        step();
        total++; if (ex_invalid_o !== 1'b0 || ex_wreg_o !== 1'b0 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL sync: got %0h/%0h/%0h want 0/0/1", ex_invalid_o, ex_wreg_o, ex_valid_o); end
        inst_i = itype(6'h0D, 5'd0, 5'd1, 16'h1234); if_valid_i = 1'b0;
        step();
        total++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL nvalid: got %0h/%0h want 0/0", ex_valid_o, ex_wreg_o); end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_hazard();
        test_shift_lui();
        test_control();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
